srff_bank_arbiter: RTL and testbench

Round-robin arbiter that shares a bank of SR flags between several requesters. Each requester issues a set, reset or hold command for one flag index. The arbiter grants one requester at a time and applies the command with SR flip-flop semantics: S=R=1 holds the previous value. It sits between control agents and the shared status-flag bank and is the only writer of that bank.

---
 rtl/srff_bank_arbiter.sv | 153 +++++++++++++++
 tb/tb_srff_bank_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/srff_bank_arbiter.sv
// srff_bank_arbiter: round-robin arbiter that serialises set/reset/hold
// commands from NREQ requesters onto a shared bank of SR flags.
// One command is granted, then applied on the following edge, so the bank
// absorbs at most one command every two cycles.

// One SR flag of the bank. Clear has priority; S=R=1 and S=R=0 both hold.
module srff_cell (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q
);
    // flag update: async reset, then bank clear, then enabled SR command
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 q <= 1'b0;
        else if (clr)              q <= 1'b0;
        else if (en && (s != r))   q <= s;
    end
endmodule

module srff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int NFLAG = 8,
    parameter int IDX_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_s,
    input  logic [NREQ-1:0]       req_r,
    input  logic [NREQ*IDX_W-1:0] req_idx,
    input  logic                  clr_all,
    output logic [NREQ-1:0]       gnt,
    output logic [NFLAG-1:0]      flags,
    output logic                  busy,
    output logic                  sr_illegal
);
    localparam int PTR_W = $clog2(NREQ);

    typedef struct packed {
        logic             s;
        logic             r;
        logic [IDX_W-1:0] idx;
    } cmd_t;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t                      state, state_nxt;
    logic [PTR_W-1:0]            ptr, ptr_inc, win, win_r;
    logic                        any_req;
    logic [NREQ-1:0][IDX_W-1:0]  idx_arr;
    cmd_t                        cmd, cmd_sel;
    logic [NREQ-1:0]             gnt_nxt;
    logic                        cmd_ld, apply;

    assign idx_arr = req_idx;

    // round-robin pick: first requester at or above ptr, wrapping at NREQ
    always_comb begin
        int c;
        c       = 0;
        any_req = 1'b0;
        win     = ptr;
        for (int k = 0; k < NREQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NREQ) c = c - NREQ;
            if (!any_req && req[c]) begin
                any_req = 1'b1;
                win     = c[PTR_W-1:0];
            end
        end
    end

    // command of the current round-robin winner, latched on the grant edge
    always_comb begin
        cmd_sel.s   = req_s[win];
        cmd_sel.r   = req_r[win];
        cmd_sel.idx = idx_arr[win];
    end

    // after serving win_r, the next requester up gets first look
    assign ptr_inc = (win_r == PTR_W'(NREQ - 1)) ? '0 : win_r + 1'b1;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state: any request opens a grant, a grant always lasts one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = GRANT;
            GRANT:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: grant/latch in IDLE, apply in GRANT (req ignored there)
    always_comb begin
        gnt_nxt = '0;
        cmd_ld  = 1'b0;
        apply   = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_nxt = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    cmd_ld  = 1'b1;
                end
            end
            GRANT:   apply = 1'b1;
            default: ;
        endcase
    end

    // grant, command latch, pointer and illegal-command pulse registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt        <= '0;
            cmd        <= '0;
            win_r      <= '0;
            ptr        <= '0;
            sr_illegal <= 1'b0;
        end else begin
            gnt        <= gnt_nxt;
            sr_illegal <= apply && cmd.s && cmd.r;
            if (cmd_ld) begin
                cmd   <= cmd_sel;
                win_r <= win;
            end
            if (apply) ptr <= ptr_inc;
        end
    end

    assign busy = (state == GRANT);

    // flag bank: only the addressed cell sees the applied command
    for (genvar i = 0; i < NFLAG; i++) begin : g_flag
        srff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .clr   (clr_all),
            .en    (apply && (cmd.idx == IDX_W'(i))),
            .s     (cmd.s),
            .r     (cmd.r),
            .q     (flags[i])
        );
    end
endmodule

// File: tb/tb_srff_bank_arbiter.sv
// Bench for srff_bank_arbiter: directed scenarios with literal expectations
// plus a randomized run, all outputs compared every cycle to a behavioural model.
module tb_srff_bank_arbiter;
    localparam int NREQ = 4, NFLAG = 8, IDX_W = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req, req_s, req_r;
    logic [NREQ*IDX_W-1:0] req_idx;
    logic                  clr_all;
    logic [NREQ-1:0]       gnt;
    logic [NFLAG-1:0]      flags;
    logic                  busy, sr_illegal;

    int n_cmp = 0, n_err = 0;
    bit chk_on = 1'b0;

    srff_bank_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .req(req), .req_s(req_s), .req_r(req_r),
        .req_idx(req_idx), .clr_all(clr_all), .gnt(gnt), .flags(flags),
        .busy(busy), .sr_illegal(sr_illegal)
    );

    always #5 clk = ~clk;

    // model: one pending command at most; apply it, else look for a new winner
    bit [NREQ-1:0]  m_gnt   = '0;
    bit [NFLAG-1:0] m_flags = '0;
    bit             m_busy  = 1'b0, m_ill = 1'b0, m_s = 1'b0, m_r = 1'b0;
    int             m_ptr = 0, m_win = 0, m_idx = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_gnt <= '0; m_flags <= '0; m_busy <= 1'b0; m_ill <= 1'b0;
            m_ptr <= 0;  m_win <= 0;    m_s <= 1'b0;    m_r <= 1'b0; m_idx <= 0;
        end else begin
            bit [NFLAG-1:0] nf;
            int w;
            nf = m_flags;
            w  = -1;
            m_ill <= 1'b0;
            m_gnt <= '0;
            if (m_busy) begin
                if (m_s && !m_r)      nf[m_idx] = 1'b1;
                else if (m_r && !m_s) nf[m_idx] = 1'b0;
                m_ill  <= m_s && m_r;
                m_ptr  <= (m_win + 1) % NREQ;
                m_busy <= 1'b0;
            end else begin
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                if (w >= 0) begin
                    m_busy <= 1'b1;
                    m_win  <= w;
                    m_gnt  <= NREQ'(1 << w);
                    m_s    <= req_s[w];
                    m_r    <= req_r[w];
                    m_idx  <= int'(req_idx[w*IDX_W +: IDX_W]);
                end
            end
            if (clr_all) nf = '0;
            m_flags <= nf;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("gnt",        32'(gnt),        32'(m_gnt));
            chk("flags",      32'(flags),      32'(m_flags));
            chk("busy",       32'(busy),       32'(m_busy));
            chk("sr_illegal", 32'(sr_illegal), 32'(m_ill));
        end
    end

    task automatic set_req(input int i, input bit s, input bit r, input int idx);
        req[i]   = 1'b1;
        req_s[i] = s;
        req_r[i] = r;
        req_idx[i*IDX_W +: IDX_W] = IDX_W'(idx);
    endtask

    // one full command from a lone requester; optional clr_all on the apply edge
    task automatic do_cmd(input int i, input bit s, input bit r, input int idx,
                          input bit clr, output logic [NREQ-1:0] g, output logic ill);
        @(negedge clk); set_req(i, s, r, idx);
        @(negedge clk); g = gnt; req[i] = 1'b0; clr_all = clr;
        @(negedge clk); clr_all = 1'b0; ill = sr_illegal;
    endtask

    task automatic pulse_reset();
        @(negedge clk); #2 reset = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] g;
        logic            ill;
        logic [NREQ-1:0] got [4];
        int              cyc [4];
        int              n;

        reset = 1'b1; req = '0; req_s = '0; req_r = '0; req_idx = '0; clr_all = 1'b0;
        #11;
        chk("rst_flags", 32'(flags), 32'h00);
        chk("rst_gnt",   32'(gnt),   32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        #1 reset = 1'b0;
        chk_on = 1'b1;

        // reset during GRANT discards the latched set of flag 5
        @(negedge clk); set_req(0, 1'b1, 1'b0, 5);
        @(negedge clk); chk("midrst_gnt", 32'(gnt), 32'b0001); req = '0;
        #2 reset = 1'b1;
        #1 chk("midrst_async_gnt",  32'(gnt),  32'h0);
        chk("midrst_async_busy", 32'(busy), 32'h0);
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("midrst_flags", 32'(flags), 32'h00);

        // single requester set then clear of flag 3
        do_cmd(0, 1'b1, 1'b0, 3, 1'b0, g, ill);
        chk("single_gnt",       32'(g),     32'b0001);
        chk("single_gnt_drop",  32'(gnt),   32'h0);
        chk("single_set",       32'(flags), 32'h08);
        do_cmd(0, 1'b0, 1'b1, 3, 1'b0, g, ill);
        chk("single_clr",       32'(flags), 32'h00);

        // round robin with all four requesting
        pulse_reset();
        n = 0;
        for (int k = 0; k < 4; k++) begin got[k] = '0; cyc[k] = -1; end
        @(negedge clk);
        for (int k = 0; k < 4; k++) set_req(k, 1'b1, 1'b0, k);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (gnt != '0 && n < 4) begin
                got[n] = gnt; cyc[n] = c; n++;
                req = req & ~gnt;
            end
        end
        chk("rr_count", 32'(n), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("rr_order",   32'(got[k]), 32'(1 << k));
            chk("rr_spacing", 32'(cyc[k]), 32'(2 * k));
        end
        chk("rr_flags", 32'(flags), 32'h0F);
        set_req(0, 1'b0, 1'b0, 0); set_req(2, 1'b0, 1'b0, 0);
        @(negedge clk); chk("rr_wrap_first", 32'(gnt), 32'b0001); req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); chk("rr_wrap_second", 32'(gnt), 32'b0100); req[2] = 1'b0;
        @(negedge clk); chk("rr_wrap_flags", 32'(flags), 32'h0F);

        // hold cases on flag 4
        pulse_reset();
        do_cmd(1, 1'b1, 1'b0, 4, 1'b0, g, ill);
        chk("hold_setup", 32'(flags), 32'h10);
        do_cmd(1, 1'b1, 1'b1, 4, 1'b0, g, ill);
        chk("hold_ill_pulse", 32'(ill),   32'h1);
        chk("hold_ss_flags",  32'(flags), 32'h10);
        do_cmd(1, 1'b0, 1'b0, 4, 1'b0, g, ill);
        chk("hold_00_ill",    32'(ill),   32'h0);
        chk("hold_00_flags",  32'(flags), 32'h10);

        // clr_all beats a set applied on the same edge
        pulse_reset();
        for (int j = 0; j < 8; j++) do_cmd(j % 4, 1'b1, 1'b0, j, 1'b0, g, ill);
        chk("clr_setup", 32'(flags), 32'hFF);
        do_cmd(0, 1'b1, 1'b0, 2, 1'b1, g, ill);
        chk("clr_flags", 32'(flags), 32'h00);
        set_req(0, 1'b0, 1'b0, 0); set_req(1, 1'b0, 1'b0, 0);
        @(negedge clk); chk("clr_ptr_adv", 32'(gnt), 32'b0010); req = '0;
        @(negedge clk);

        // late drop, alone: requester 2 is granted again
        pulse_reset();
        @(negedge clk); set_req(2, 1'b0, 1'b0, 0);
        @(negedge clk); chk("late_first", 32'(gnt), 32'b0100);
        @(negedge clk);
        @(negedge clk); chk("late_regrant", 32'(gnt), 32'b0100); req = '0;
        @(negedge clk);

        // late drop with requester 3 pending: 3 goes ahead of 2
        pulse_reset();
        @(negedge clk); set_req(2, 1'b0, 1'b0, 0); set_req(3, 1'b0, 1'b0, 0);
        @(negedge clk); chk("late_b_first", 32'(gnt), 32'b0100);
        @(negedge clk);
        @(negedge clk); chk("late_b_next", 32'(gnt), 32'b1000); req = '0;
        @(negedge clk);

        // randomized traffic including clr_all and occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            req     = NREQ'($urandom);
            req_s   = NREQ'($urandom);
            req_r   = NREQ'($urandom);
            req_idx = (NREQ*IDX_W)'($urandom);
            clr_all = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 199) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk); #2 reset = 1'b0;
            end
        end
        @(negedge clk);
        req = '0; clr_all = 1'b0;
        @(negedge clk); @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
